// File: rtl/rob_retire.sv
// Reorder buffer with in-order retirement: hands out tags, tracks completion,
// and returns superseded physical registers. Optional flush via `ROB_FLUSH_EN.
module rob_retire #(
  parameter int ENTRIES   = 32,
  parameter int WIDTH     = 4,
  parameter int CPL       = 4,
  parameter int RETIRE    = 6,
  parameter int PR_ADDR_W = 6
) (
  input  logic                                  clk,
  input  logic                                  rst,
`ifdef ROB_FLUSH_EN
  input  logic                                  flush,
`endif
  input  logic [WIDTH-1:0]                      alloc_valid,
  input  logic [WIDTH*PR_ADDR_W-1:0]            alloc_old_regs,
  output logic                                  alloc_ready,
  output logic [WIDTH*$clog2(ENTRIES)-1:0]      rob_entries,
  input  logic [CPL-1:0]                        cpl_valid,
  input  logic [CPL*$clog2(ENTRIES)-1:0]        cpl_entry,
  output logic [RETIRE*PR_ADDR_W-1:0]           cmplt_free_regs,
  output logic [$clog2(RETIRE+1)-1:0]           retire_count,
  output logic [$clog2(ENTRIES):0]              rob_count
);

  localparam int TAG_W = $clog2(ENTRIES);
  localparam int CNT_W = TAG_W + 1;
  localparam int RC_W  = $clog2(RETIRE + 1);
  localparam int NW_W  = $clog2(WIDTH + 1);

  logic [ENTRIES-1:0]          r_valid;
  logic [ENTRIES-1:0]          r_done;
  logic [PR_ADDR_W-1:0]        r_old_reg [ENTRIES];
  logic [TAG_W-1:0]            r_head;
  logic [TAG_W-1:0]            r_tail;
  logic [CNT_W-1:0]            r_count;
  logic [RETIRE*PR_ADDR_W-1:0] r_free_regs;
  logic [RC_W-1:0]             r_retire_count;

  logic                        w_flush;
  logic [CNT_W-1:0]            w_space;
  logic                        w_alloc_ready;
  logic                        w_alloc_fire;
  logic [NW_W-1:0]             w_n;
  logic [RC_W-1:0]             w_r;
  logic [ENTRIES-1:0]          w_alloc_mask;
  logic [ENTRIES-1:0]          w_cpl_mask;
  logic [ENTRIES-1:0]          w_ret_mask;
  logic [RETIRE*PR_ADDR_W-1:0] w_free;
  logic                        w_stop;
  logic [TAG_W-1:0]            w_idx;
  int                          w_slot;

`ifdef ROB_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Readiness looks only at registered occupancy, never at same-cycle retirement.
  assign w_space       = CNT_W'(ENTRIES) - r_count;
  assign w_alloc_ready = (w_space >= CNT_W'(WIDTH));
  assign w_alloc_fire  = w_alloc_ready && (|alloc_valid) && !w_flush;

  always_comb begin
    w_n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_n = w_n + NW_W'(alloc_valid[i]);
    end
  end

  always_comb begin
    w_alloc_mask = '0;
    rob_entries  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rob_entries[i*TAG_W +: TAG_W] = r_tail + TAG_W'(i);
      if (w_alloc_fire && alloc_valid[i]) begin
        w_alloc_mask[r_tail + TAG_W'(i)] = 1'b1;
      end
    end
  end

  always_comb begin
    w_cpl_mask = '0;
    for (int p = 0; p < CPL; p++) begin
      if (cpl_valid[p] && !w_flush) begin
        w_cpl_mask[cpl_entry[p*TAG_W +: TAG_W]] = 1'b1;
      end
    end
  end

  // Retire the run of valid+done entries from head; pack frees (old_reg > 1) low-first.
  always_comb begin
    w_r        = '0;
    w_stop     = w_flush;
    w_ret_mask = '0;
    w_free     = '0;
    w_slot     = 0;
    w_idx      = r_head;
    for (int k = 0; k < RETIRE; k++) begin
      w_idx = r_head + TAG_W'(k);
      if (!w_stop && r_valid[w_idx] && r_done[w_idx]) begin
        w_r               = w_r + RC_W'(1);
        w_ret_mask[w_idx] = 1'b1;
        if (r_old_reg[w_idx] > PR_ADDR_W'(1)) begin
          w_free[w_slot*PR_ADDR_W +: PR_ADDR_W] = r_old_reg[w_idx];
          w_slot = w_slot + 1;
        end
      end else begin
        w_stop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid        <= '0;
      r_done         <= '0;
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_free_regs    <= '0;
      r_retire_count <= '0;
    end else begin
      r_free_regs    <= w_free;
      r_retire_count <= w_r;
      if (w_flush) begin
        r_valid <= '0;
        r_done  <= '0;
        r_tail  <= r_head;
        r_count <= '0;
      end else begin
        r_head  <= r_head + TAG_W'(w_r);
        if (w_alloc_fire) begin
          r_tail <= r_tail + TAG_W'(w_n);
        end
        r_count <= r_count + (w_alloc_fire ? CNT_W'(w_n) : CNT_W'(0)) - CNT_W'(w_r);
        r_valid <= (r_valid & ~w_ret_mask) | w_alloc_mask;
        // Completions only land on entries that were already valid.
        r_done  <= (r_done | (w_cpl_mask & r_valid)) & ~w_ret_mask & ~w_alloc_mask;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (w_alloc_fire && alloc_valid[i]) begin
        r_old_reg[r_tail + TAG_W'(i)] <= alloc_old_regs[i*PR_ADDR_W +: PR_ADDR_W];
      end
    end
  end

  assign alloc_ready     = w_alloc_ready;
  assign cmplt_free_regs = r_free_regs;
  assign retire_count    = r_retire_count;
  assign rob_count       = r_count;

endmodule

// File: tb/tb_rob_retire.sv
// Scoreboard bench for rob_retire: a queue-based ROB model predicts each cycle's
// outputs, and a monitor compares them one cycle later.
module tb_rob_retire;
  localparam int ENTRIES = 32;
  localparam int WIDTH   = 4;
  localparam int CPL     = 4;
  localparam int RETIRE  = 6;
  localparam int PR      = 6;
  localparam int TAG_W   = 5;
  localparam int RC_W    = 3;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    flush = 1'b0;
  logic [WIDTH-1:0]        alloc_valid = '0;
  logic [WIDTH*PR-1:0]     alloc_old_regs = '0;
  logic                    alloc_ready;
  logic [WIDTH*TAG_W-1:0]  rob_entries;
  logic [CPL-1:0]          cpl_valid = '0;
  logic [CPL*TAG_W-1:0]    cpl_entry = '0;
  logic [RETIRE*PR-1:0]    cmplt_free_regs;
  logic [RC_W-1:0]         retire_count;
  logic [TAG_W:0]          rob_count;

  rob_retire #(.ENTRIES(ENTRIES), .WIDTH(WIDTH), .CPL(CPL), .RETIRE(RETIRE), .PR_ADDR_W(PR)) dut (
    .clk(clk),
    .rst(rst),
`ifdef ROB_FLUSH_EN
    .flush(flush),
`endif
    .alloc_valid(alloc_valid),
    .alloc_old_regs(alloc_old_regs),
    .alloc_ready(alloc_ready),
    .rob_entries(rob_entries),
    .cpl_valid(cpl_valid),
    .cpl_entry(cpl_entry),
    .cmplt_free_regs(cmplt_free_regs),
    .retire_count(retire_count),
    .rob_count(rob_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tag;
    int old;
    bit done;
  } ent_t;

  typedef struct {
    int                   rc;
    logic [RETIRE*PR-1:0] fr;
    int                   cnt;
    bit                   rdy;
    logic [WIDTH*TAG_W-1:0] ents;
  } exp_t;

  ent_t rob_q[$];
  exp_t exp_q[$];
  int   head_tag = 0;
  int   passed = 0;
  int   total = 0;
  bit   mon_en = 1'b0;

  int   st_n;
  bit   st_fl;
  int   st_old [WIDTH];
  bit   st_cv [CPL];
  int   st_ct [CPL];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  function automatic logic [WIDTH*TAG_W-1:0] tags_from(input int base);
    logic [WIDTH*TAG_W-1:0] v;
    v = '0;
    for (int i = 0; i < WIDTH; i++) v[i*TAG_W +: TAG_W] = TAG_W'((base + i) % ENTRIES);
    return v;
  endfunction

  task automatic clr();
    st_n  = 0;
    st_fl = 1'b0;
    for (int i = 0; i < WIDTH; i++) st_old[i] = 0;
    for (int p = 0; p < CPL; p++) begin
      st_cv[p] = 1'b0;
      st_ct[p] = 0;
    end
  endtask

  // Complete up to k of the oldest not-yet-done entries, optionally leaving the head alone.
  task automatic cpl_oldest(input int k, input bit skip_head);
    int p;
    p = 0;
    for (int i = 0; i < rob_q.size() && p < k; i++) begin
      if (!rob_q[i].done && !(skip_head && i == 0)) begin
        st_cv[p] = 1'b1;
        st_ct[p] = rob_q[i].tag;
        p++;
      end
    end
  endtask

  // Drive one cycle of stimulus and push the model's prediction for after the edge.
  task automatic step();
    int   size0;
    int   tail0;
    bit   rdy0;
    int   r;
    int   slot;
    exp_t e;
    @(negedge clk);
    alloc_valid = WIDTH'((1 << st_n) - 1);
    for (int i = 0; i < WIDTH; i++) alloc_old_regs[i*PR +: PR] = PR'(st_old[i]);
    for (int p = 0; p < CPL; p++) begin
      cpl_valid[p]                 = st_cv[p];
      cpl_entry[p*TAG_W +: TAG_W]  = TAG_W'(st_ct[p]);
    end
    flush = st_fl;

    size0 = rob_q.size();
    tail0 = (head_tag + size0) % ENTRIES;
    rdy0  = (ENTRIES - size0) >= WIDTH;
    r     = 0;
    slot  = 0;
    e.fr  = '0;
`ifdef ROB_FLUSH_EN
    if (st_fl) rob_q.delete();
    else begin
`else
    begin
`endif
      while (r < RETIRE && r < rob_q.size() && rob_q[r].done) begin
        if (rob_q[r].old > 1) begin
          e.fr[slot*PR +: PR] = PR'(rob_q[r].old);
          slot++;
        end
        r++;
      end
      repeat (r) void'(rob_q.pop_front());
      head_tag = (head_tag + r) % ENTRIES;
      for (int p = 0; p < CPL; p++) begin
        if (st_cv[p]) begin
          for (int i = 0; i < rob_q.size(); i++) if (rob_q[i].tag == st_ct[p]) rob_q[i].done = 1'b1;
        end
      end
      if (rdy0 && st_n > 0) begin
        for (int i = 0; i < st_n; i++) begin
          ent_t n;
          n.tag  = (tail0 + i) % ENTRIES;
          n.old  = st_old[i];
          n.done = 1'b0;
          rob_q.push_back(n);
        end
      end
    end
    e.rc   = r;
    e.cnt  = rob_q.size();
    e.rdy  = (ENTRIES - rob_q.size()) >= WIDTH;
    e.ents = tags_from(head_tag + rob_q.size());
    exp_q.push_back(e);
    mon_en = 1'b1;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      clr();
      step();
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_alloc_ready"}, 64'(alloc_ready), 64'd1);
    chk({tag, "_rob_entries"}, 64'(rob_entries), 64'(tags_from(0)));
    chk({tag, "_rob_count"}, 64'(rob_count), 64'd0);
    chk({tag, "_free_regs"}, 64'(cmplt_free_regs), 64'd0);
    chk({tag, "_retire_count"}, 64'(retire_count), 64'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL scoreboard_empty: got no expectation, required one per cycle");
        end else begin
          e = exp_q.pop_front();
          chk("retire_count", 64'(retire_count), 64'(e.rc));
          chk("cmplt_free_regs", 64'(cmplt_free_regs), 64'(e.fr));
          chk("rob_count", 64'(rob_count), 64'(e.cnt));
          chk("alloc_ready", 64'(alloc_ready), 64'(e.rdy));
          chk("rob_entries", 64'(rob_entries), 64'(e.ents));
        end
      end
    end
  end

  initial begin : driver
    clr();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_state("reset");

    // Basic allocate then complete all four together.
    clr(); st_n = 4; st_old[0] = 2; st_old[1] = 5; st_old[2] = 7; st_old[3] = 9; step();
    clr(); for (int p = 0; p < 4; p++) begin st_cv[p] = 1'b1; st_ct[p] = p; end step();
    idle(2);

    // Head blocks retirement until it completes.
    clr(); st_n = 4; for (int i = 0; i < 4; i++) st_old[i] = 10 + i; step();
    clr(); cpl_oldest(3, 1'b1); step();
    idle(2);
    clr(); cpl_oldest(1, 1'b0); step();
    idle(2);

    // Fill to capacity, try to allocate while full, then drain through the wrap.
    for (int j = 0; j < 8; j++) begin
      clr(); st_n = 4;
      for (int i = 0; i < 4; i++) st_old[i] = $urandom_range(0, 63);
      step();
    end
    clr(); st_n = 4; st_old[0] = 33; cpl_oldest(4, 1'b0); step();
    for (int j = 0; j < 7; j++) begin clr(); cpl_oldest(4, 1'b0); step(); end
    idle(4);

    // Eight done entries at head, allocate two on the retiring edge; cap at six.
    clr(); st_n = 4; st_old[0] = 0; st_old[1] = 1; st_old[2] = 5; st_old[3] = 1; step();
    clr(); st_n = 4; st_old[0] = 9; st_old[1] = 0; st_old[2] = 12; st_old[3] = 13; step();
    clr(); cpl_oldest(4, 1'b1); step();
    clr(); cpl_oldest(4, 1'b1); step();
    clr(); cpl_oldest(1, 1'b0); step();
    clr(); st_n = 2; st_old[0] = 0; st_old[1] = 1; step();
    idle(3);

`ifdef ROB_FLUSH_EN
    clr(); st_n = 4; for (int i = 0; i < 4; i++) st_old[i] = 20 + i; step();
    clr(); st_n = 4; for (int i = 0; i < 4; i++) st_old[i] = 30 + i; step();
    clr(); st_n = 2; st_old[0] = 40; st_old[1] = 41; step();
    clr(); st_fl = 1'b1; st_n = 4; cpl_oldest(4, 1'b0); step();
    idle(2);
`endif

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      clr();
      st_n = $urandom_range(0, WIDTH);
      for (int i = 0; i < WIDTH; i++)
        st_old[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1) : $urandom_range(0, 63);
      for (int p = 0; p < CPL; p++) begin
        if ($urandom_range(0, 9) < 6) begin
          st_cv[p] = 1'b1;
          if (rob_q.size() > 0 && $urandom_range(0, 9) != 0)
            st_ct[p] = rob_q[$urandom_range(0, rob_q.size() - 1)].tag;
          else
            st_ct[p] = $urandom_range(0, ENTRIES - 1);
        end
      end
`ifdef ROB_FLUSH_EN
      st_fl = ($urandom_range(0, 49) == 0);
`endif
      step();
    end

    // Asynchronous reset with entries outstanding discards them without frees.
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    clr();
    alloc_valid = '0;
    cpl_valid   = '0;
    flush       = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_reset_state("midreset");
    @(negedge clk);
    rst = 1'b1;
    rob_q.delete();
    head_tag = 0;
    for (int c = 0; c < 60; c++) begin
      clr();
      st_n = $urandom_range(0, WIDTH);
      for (int i = 0; i < WIDTH; i++) st_old[i] = $urandom_range(0, 63);
      cpl_oldest($urandom_range(0, CPL), 1'b0);
      step();
    end

    @(posedge clk);
    #3;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rob_retire.md
# rob_retire

Reorder buffer and in-order retirement for the out-of-order 6502 core. It hands out ROB entry tags to the rename/decode stage in program order and records each op's superseded physical register. It marks entries done as execution results complete, and retires the oldest done entries in order. Retirement returns the superseded physical registers to the decoder's free pool over the `cmplt_free_regs` bus.

## Interface
Parameters:
- `ENTRIES`, 32: ROB depth; power of two; tag width `TAG_W = $clog2(ENTRIES)`, 5 at default.
- `WIDTH`, 4: allocation slots per cycle, matching decoder width.
- `CPL`, 4: completion ports per cycle.
- `RETIRE`, 6: maximum retirements per cycle.

Ports (`PR_ADDR_W` from `constants.vh`):
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `alloc_valid` in WIDTH: per-slot allocation request; must be a low-aligned prefix (e.g. 0011, not 0101).
- `alloc_old_regs` in WIDTH*PR_ADDR_W: superseded physical register per slot; values 0 and 1 mean "nothing to free".
- `alloc_ready` out 1: the ROB can accept all WIDTH slots this cycle.
- `rob_entries` out WIDTH*TAG_W: tags slot i will receive, i.e. `tail+i mod ENTRIES`.
- `cpl_valid` in CPL: completion strobe per port.
- `cpl_entry` in CPL*TAG_W: tag of the completing op.
- `cmplt_free_regs` out RETIRE*PR_ADDR_W: freed registers, packed low-first; unused slots are 0.
- `retire_count` out $clog2(RETIRE+1): number of ops retired in the previous cycle.
- `rob_count` out TAG_W+1: current occupancy.

## Operation
- Per-entry state: `valid`, `done`, `old_reg`. Pointers `head`, `tail` are TAG_W bits and wrap mod ENTRIES. `count` is TAG_W+1 bits.
- **Allocate:** fires on an edge where `alloc_ready` is high and `alloc_valid` is not 0.
  - Let n = popcount(`alloc_valid`). Entries `tail..tail+n-1` get valid=1, done=0, and `old_reg` from slot i.
  - `tail += n`.
- **Complete:** each `cpl_valid[p]` sets `done` on `cpl_entry[p]`. If the target entry is not valid, the strobe is ignored. Duplicate tags on multiple ports are harmless.
- **Retire:** r is the length of the run of entries from `head` with valid and done both set, capped at RETIRE. It is evaluated on the registered state.
  - Retired entries are cleared and `head += r`.
  - Each retired `old_reg` greater than 1 is packed into `cmplt_free_regs` in program order. Values 0 and 1 produce no slot.
  - `retire_count` = r.
- **Occupancy:** `count_next = count + n - r`. Allocate, complete and retire may all fire on the same edge.
- `alloc_ready = (ENTRIES - count) >= WIDTH`. It is computed from registered count only; same-cycle retirement does not raise it.
- **Full** (count == ENTRIES): `alloc_ready` is 0 and `rob_entries` still shows `tail..`.
- **Empty** (count == 0): r = 0 and `head` == `tail`.
- The only control state is the pointers and count; there is no FSM beyond them.

## Timing
- **Reset, asynchronous while `rst` is low:**
  - `head` = `tail` = `count` = 0; all valid/done are 0.
  - `cmplt_free_regs` = 0, `retire_count` = 0, `rob_count` = 0.
  - `alloc_ready` = 1; `rob_entries` = {3,2,1,0}.
- Reset mid-operation discards every entry without producing frees.
- Allocation latency: tags appear on `rob_entries` combinationally. They advance on the edge that accepts the request.
- Completion-to-retire: a completion sampled at edge k can retire at edge k+1 at the earliest. The corresponding `cmplt_free_regs` slot is driven during the cycle after edge k+1.
- `cmplt_free_regs` and `retire_count` are registered and hold for exactly one cycle. They return to 0 when nothing retires.
- A completion and a retirement of the same entry never occur on one edge, because retirement reads only the registered `done`.

## Configuration
- `ROB_FLUSH_EN` defined:
  - Adds input `flush` (1 bit).
  - On an edge with `flush`=1: every entry is cleared, `tail` ← `head`, and `count` ← 0.
  - Allocate, complete and retire are all suppressed that edge. `cmplt_free_regs` and `retire_count` are 0 the following cycle.
  - `flush` takes priority over all other inputs.
- `ROB_FLUSH_EN` undefined: no `flush` port; entries leave only by retirement.

## Test plan
- **Reset:** hold `rst`=0 two cycles, release → `alloc_ready`=1, `rob_entries`={3,2,1,0}, `rob_count`=0, `cmplt_free_regs`=0.
- **Allocate and retire:** allocate 4 with old regs {2,5,7,9}; complete tags 0–3 on one edge → next edge `retire_count`=4 and `cmplt_free_regs` low slots = 2,5,7,9; `rob_count`=0.
- **In-order blocking:** allocate 4; complete only tags 1–3 → `retire_count` stays 0. Complete tag 0 → all 4 retire together.
- **Full and wrap-around:** allocate 8×4 → `rob_count`=32, `alloc_ready`=0. Complete and retire 6 (r=6), then 2 more → `alloc_ready`=1 and `rob_entries`={3,2,1,0} again after the wrap.
- **Simultaneous events and cap:** with 8 done entries at head, allocate 2 on the same edge → `retire_count`=6, `rob_count` = 8+2−6 = 4; old regs 0/1 yield zero slots.
- **Flush (`ROB_FLUSH_EN`):** 10 entries outstanding, assert `flush` together with completions → `rob_count`=0, no frees, and the next `rob_entries` start at the old `head`.
